seg_display_bank: RTL and testbench

- Parametrised multi-digit seven-segment driver; generalises the fixed per-digit hex decoders on the DE2 HEX0..HEX7 outputs.
- Latches a value from the processor or keyboard path and shows it on NUM_DIGITS digits in hex or decimal.
- Decimal mode uses a sequential double-dabble (shift-add-3) converter, one input bit per cycle.
- Also provides leading-zero blanking, overflow indication and single-entry write buffering.

---
 rtl/seg_display_bank.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_display_bank.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_bank.sv
// seg_display_bank: multi-digit seven-segment driver (hex or decimal).
// Decimal values pass through a one-bit-per-cycle double-dabble unit.
// Ports: clock, resetn (async, active low), wr_en/wr_data/wr_dec write,
//   blank_lz level, seg_out active-low a..g per digit, busy, overflow.
// Optional blink: define SEG_DISPLAY_BANK_BLINK_EN (adds BLINK_DIV and
//   blink_mask[NUM_DIGITS-1:0]).
module seg_display_bank #(
    parameter int NUM_DIGITS  = 8,
    parameter int VALUE_WIDTH = 32
`ifdef SEG_DISPLAY_BANK_BLINK_EN
    ,
    parameter int BLINK_DIV   = 5_000_000
`endif
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [VALUE_WIDTH-1:0]   wr_data,
    input  logic                     wr_dec,
    input  logic                     blank_lz,
`ifdef SEG_DISPLAY_BANK_BLINK_EN
    input  logic [NUM_DIGITS-1:0]    blink_mask,
`endif
    output logic [7*NUM_DIGITS-1:0]  seg_out,
    output logic                     busy,
    output logic                     overflow
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int XW = (VALUE_WIDTH > DW) ? VALUE_WIDTH : DW;
    localparam int CW = $clog2(VALUE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t                 state_q;
    logic [DW-1:0]          dig_q;
    logic [DW-1:0]          bcd_q;
    logic [DW-1:0]          bcd_adj;
    logic [VALUE_WIDTH-1:0] sh_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;
    logic                   sticky_q;
    logic                   shown_q;
    logic                   pend_v_q;
    logic                   pend_dec_q;
    logic [VALUE_WIDTH-1:0] pend_data_q;

    // Next work item: a buffered write always goes ahead of a new one.
    logic [VALUE_WIDTH-1:0] item_data;
    logic                   item_dec;
    logic [XW-1:0]          item_ext;
    logic [DW-1:0]          item_hex;
    logic                   item_hex_ovf;

    always_comb begin
        item_data    = pend_v_q ? pend_data_q : wr_data;
        item_dec     = pend_v_q ? pend_dec_q : wr_dec;
        item_ext     = XW'(item_data);
        item_hex     = item_ext[DW-1:0];
        item_hex_ovf = |(item_ext >> DW);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            dig_q       <= '0;
            bcd_q       <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            shown_q     <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_dec_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pend_v_q) begin
                        pend_v_q <= wr_en;
                        if (wr_en) begin
                            pend_data_q <= wr_data;
                            pend_dec_q  <= wr_dec;
                        end
                    end
                    if (pend_v_q || wr_en) begin
                        if (item_dec) begin
                            sh_q     <= item_data;
                            bcd_q    <= '0;
                            sticky_q <= 1'b0;
                            cnt_q    <= CW'(VALUE_WIDTH - 1);
                            state_q  <= S_CONV;
                        end else begin
                            dig_q   <= item_hex;
                            ovf_q   <= item_hex_ovf;
                            shown_q <= 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    if (wr_en) begin
                        pend_v_q    <= 1'b1;
                        pend_data_q <= wr_data;
                        pend_dec_q  <= wr_dec;
                    end
                    sh_q     <= sh_q << 1;
                    bcd_q    <= {bcd_adj[DW-2:0], sh_q[VALUE_WIDTH-1]};
                    // a carry out of the top digit means too many digits
                    sticky_q <= sticky_q | bcd_adj[DW-1];
                    if (cnt_q == '0)
                        state_q <= S_COMMIT;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                S_COMMIT: begin
                    // a write landing here is always queued for next time
                    pend_v_q <= wr_en;
                    if (wr_en) begin
                        pend_data_q <= wr_data;
                        pend_dec_q  <= wr_dec;
                    end
                    shown_q <= 1'b1;
                    state_q <= S_IDLE;
                    // a later hex write supersedes the converted value
                    if (pend_v_q && !pend_dec_q) begin
                        dig_q <= item_hex;
                        ovf_q <= item_hex_ovf;
                    end else begin
                        dig_q <= bcd_q;
                        ovf_q <= sticky_q;
                    end
                    if (pend_v_q && pend_dec_q) begin
                        sh_q     <= item_data;
                        bcd_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CW'(VALUE_WIDTH - 1);
                        state_q  <= S_CONV;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE) | pend_v_q;
    assign overflow = ovf_q;

`ifdef SEG_DISPLAY_BANK_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_off_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_off_q <= ~blink_off_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`endif

    function automatic logic [6:0] seg7(input logic [3:0] n);
        unique case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    logic       zero_above;
    logic [3:0] nib;
    logic [6:0] seg;

    // Walk from the top digit down so zero_above covers this digit too.
    always_comb begin
        seg_out    = '1;
        zero_above = 1'b1;
        nib        = 4'h0;
        seg        = 7'h7F;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib        = dig_q[4*i +: 4];
            zero_above = zero_above & (nib == 4'h0);
            if (!shown_q)
                seg = 7'h7F;
            else if (ovf_q)
                seg = 7'h3F;
            else if (blank_lz && zero_above && i != 0)
                seg = 7'h7F;
            else
                seg = seg7(nib);
`ifdef SEG_DISPLAY_BANK_BLINK_EN
            if (blink_off_q && blink_mask[i])
                seg = 7'h7F;
`endif
            seg_out[7*i +: 7] = seg;
        end
    end

endmodule

// File: tb/tb_seg_display_bank.sv
// tb_seg_display_bank: randomized self-checking bench for seg_display_bank.
// Expected displays come from arithmetic on the written value.
module tb_seg_display_bank;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_dec = 1'b0;
    logic        blank_lz = 1'b0;
    logic [55:0] seg_out;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // model of what the display should currently hold
    bit              m_shown = 1'b0;
    longint unsigned m_val = 0;
    bit              m_dec = 1'b0;

    logic [6:0] enc_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_display_bank #(
        .NUM_DIGITS (8),
        .VALUE_WIDTH(32)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_dec  (wr_dec),
        .blank_lz(blank_lz),
        .seg_out (seg_out),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic bit exp_ovf(bit shown, longint unsigned v, bit dec);
        longint unsigned lim;
        lim = dec ? 64'd100000000 : 64'h1_0000_0000;
        return shown && (v >= lim);
    endfunction

    function automatic logic [55:0] exp_seg(bit shown, longint unsigned v,
                                            bit dec, bit blz);
        longint unsigned base;
        longint unsigned p;
        logic [55:0]     r;
        base = dec ? 64'd10 : 64'd16;
        p    = 1;
        r    = '1;
        for (int i = 0; i < 8; i++) begin
            if (!shown)
                r[7*i +: 7] = 7'h7F;
            else if (exp_ovf(shown, v, dec))
                r[7*i +: 7] = 7'h3F;
            else if (blz && i > 0 && v < p)
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = enc_tab[int'((v / p) % base)];
            p = p * base;
        end
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the
    // rising edge that sampled the write.
    task automatic do_write(input logic [31:0] d, input logic dec);
        wr_en   = 1'b1;
        wr_data = d;
        wr_dec  = dec;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [55:0] e;
        resetn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            wr_en   = k[0];
            wr_dec  = k[1];
            wr_data = $urandom;
        end
        @(negedge clock);
        wr_en = 1'b0;
        checks++;
        if (seg_out !== {8{7'h7F}}) begin
            errors++;
            $display("FAIL reset_seg: got %h want %h", seg_out, {8{7'h7F}});
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b ovf=%b want 0 0",
                     busy, overflow);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        e = exp_seg(m_shown, m_val, m_dec, blank_lz);
        checks++;
        if (seg_out !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: seg=%h busy=%b want %h 0",
                     seg_out, busy, e);
        end
    endtask

    task automatic test_hex();
        logic [55:0] e;
        logic [31:0] d;
        blank_lz = 1'b1;
        do_write(32'h0000ABCD, 1'b0);
        m_shown = 1; m_val = 64'hABCD; m_dec = 0;
        e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21};
        checks++;
        if (seg_out !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL hex_abcd_blank: seg=%h busy=%b want %h 0",
                     seg_out, busy, e);
        end
        blank_lz = 1'b0;
        #1;
        e = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21};
        checks++;
        if (seg_out !== e) begin
            errors++;
            $display("FAIL hex_abcd_noblank: seg=%h want %h", seg_out, e);
        end
        @(negedge clock);
        for (int n = 0; n < 12; n++) begin
            d        = $urandom >> $urandom_range(0, 31);
            blank_lz = 1'($urandom_range(0, 1));
            do_write(d, 1'b0);
            m_shown = 1; m_val = 64'(d); m_dec = 0;
            e = exp_seg(m_shown, m_val, m_dec, blank_lz);
            checks++;
            if (seg_out !== e || busy !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL hex_rand %h: seg=%h busy=%b ovf=%b want %h",
                         d, seg_out, busy, overflow, e);
            end
        end
    endtask

    task automatic test_decimal();
        logic [55:0] hold;
        logic [55:0] e;
        blank_lz = 1'b1;
        hold = exp_seg(m_shown, m_val, m_dec, blank_lz);
        do_write(32'd12345, 1'b1);
        for (int k = 0; k < 33; k++) begin
            checks++;
            if (busy !== 1'b1 || seg_out !== hold) begin
                errors++;
                $display("FAIL dec_hold cyc %0d: busy=%b seg=%h want 1 %h",
                         k, busy, seg_out, hold);
            end
            @(negedge clock);
        end
        m_shown = 1; m_val = 12345; m_dec = 1;
        e = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
        checks++;
        if (seg_out !== e || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL dec_12345: seg=%h busy=%b ovf=%b want %h 0 0",
                     seg_out, busy, overflow, e);
        end
    endtask

    task automatic test_overflow();
        logic [55:0] e;
        blank_lz = 1'b1;
        do_write(32'd100000000, 1'b1);
        repeat (33) @(negedge clock);
        m_shown = 1; m_val = 100000000; m_dec = 1;
        checks++;
        if (overflow !== 1'b1 || seg_out !== {8{7'h3F}}) begin
            errors++;
            $display("FAIL dec_ovf: ovf=%b seg=%h want 1 %h",
                     overflow, seg_out, {8{7'h3F}});
        end
        do_write(32'd0, 1'b1);
        repeat (33) @(negedge clock);
        m_val = 0;
        e = {{7{7'h7F}}, 7'h40};
        checks++;
        if (overflow !== 1'b0 || seg_out !== e) begin
            errors++;
            $display("FAIL dec_zero: ovf=%b seg=%h want 0 %h",
                     overflow, seg_out, e);
        end
    endtask

    task automatic test_random_dec();
        logic [55:0] hold;
        logic [55:0] e;
        logic [31:0] d;
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1)
                d = $urandom;
            else
                d = $urandom_range(0, 99999999) >> $urandom_range(0, 24);
            blank_lz = 1'($urandom_range(0, 1));
            hold = exp_seg(m_shown, m_val, m_dec, blank_lz);
            do_write(d, 1'b1);
            repeat (16) @(negedge clock);
            checks++;
            if (busy !== 1'b1 || seg_out !== hold) begin
                errors++;
                $display("FAIL rdec_mid %0d: busy=%b seg=%h want 1 %h",
                         d, busy, seg_out, hold);
            end
            repeat (17) @(negedge clock);
            m_shown = 1; m_val = 64'(d); m_dec = 1;
            e = exp_seg(m_shown, m_val, m_dec, blank_lz);
            checks++;
            if (seg_out !== e || busy !== 1'b0 ||
                overflow !== exp_ovf(m_shown, m_val, m_dec)) begin
                errors++;
                $display("FAIL rdec %0d: seg=%h busy=%b ovf=%b want %h 0 %b",
                         d, seg_out, busy, overflow, e,
                         exp_ovf(m_shown, m_val, m_dec));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] e7;
        logic [55:0] e42;
        logic [55:0] e99;
        bit seen7;
        bit seen42;
        bit gap;
        bit done;
        blank_lz = 1'b1;
        e7  = exp_seg(1, 7, 1, 1);
        e42 = exp_seg(1, 42, 1, 1);
        e99 = exp_seg(1, 99, 1, 1);
        seen7 = 0; seen42 = 0; gap = 0; done = 0;
        do_write(32'd7, 1'b1);
        repeat (4) @(negedge clock);
        do_write(32'd42, 1'b1);
        repeat (4) @(negedge clock);
        do_write(32'd99, 1'b1);
        for (int k = 0; k < 150 && !done; k++) begin
            if (seg_out === e7)  seen7 = 1;
            if (seg_out === e42) seen42 = 1;
            if (seg_out === e99) done = 1;
            else if (busy !== 1'b1) gap = 1;
            if (!done) @(negedge clock);
        end
        m_shown = 1; m_val = 99; m_dec = 1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL buf_timeout: seg=%h want %h", seg_out, e99);
        end
        checks++;
        if (!seen7 || seen42) begin
            errors++;
            $display("FAIL buf_order: seen7=%b seen42=%b want 1 0",
                     seen7, seen42);
        end
        checks++;
        if (gap) begin
            errors++;
            $display("FAIL buf_busy_gap: busy dropped=%b want 0", gap);
        end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL buf_final: busy=%b ovf=%b want 0 0",
                     busy, overflow);
        end
    endtask

    task automatic test_midreset();
        blank_lz = 1'b0;
        do_write(32'd54321, 1'b1);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        m_shown = 0; m_val = 0; m_dec = 0;
        checks++;
        if (seg_out !== {8{7'h7F}} || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset: seg=%h busy=%b ovf=%b want %h 0 0",
                     seg_out, busy, overflow, {8{7'h7F}});
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            checks++;
            if (seg_out !== exp_seg(m_shown, m_val, m_dec, blank_lz) ||
                busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after cyc %0d: seg=%h busy=%b",
                         k, seg_out, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_random_dec();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
